// File: rtl/scrolling_char_display_if.sv
// Bus bundle for scrolling_char_display: step/auto controls, message write port,
// and the display/status outputs. Build macro REVERSE_STEP_EN adds i_Switch_Back.
interface scrolling_char_display_if #(
    parameter int NUM_DIGITS = 2,
    parameter int DEPTH      = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                    i_Switch;
    logic                    i_Auto;
    logic                    i_Wr_En;
    logic [7:0]              i_Wr_Char;
    logic                    i_Clear;
`ifdef REVERSE_STEP_EN
    logic                    i_Switch_Back;
`endif
    logic [NUM_DIGITS*8-1:0] o_Char;
    logic [NUM_DIGITS*7-1:0] o_Segments;
    logic [CNT_W-1:0]        o_Count;
    logic                    o_Full;
    logic                    o_Overflow;
    logic                    o_Step;

`ifdef REVERSE_STEP_EN
    modport master (
        output i_Switch, i_Auto, i_Wr_En, i_Wr_Char, i_Clear, i_Switch_Back,
        input  o_Char, o_Segments, o_Count, o_Full, o_Overflow, o_Step
    );
    modport slave (
        input  i_Switch, i_Auto, i_Wr_En, i_Wr_Char, i_Clear, i_Switch_Back,
        output o_Char, o_Segments, o_Count, o_Full, o_Overflow, o_Step
    );
`else
    modport master (
        output i_Switch, i_Auto, i_Wr_En, i_Wr_Char, i_Clear,
        input  o_Char, o_Segments, o_Count, o_Full, o_Overflow, o_Step
    );
    modport slave (
        input  i_Switch, i_Auto, i_Wr_En, i_Wr_Char, i_Clear,
        output o_Char, o_Segments, o_Count, o_Full, o_Overflow, o_Step
    );
`endif
endinterface

// File: rtl/scrolling_char_display.sv
// Scrolling N-digit character display: DEPTH-char message buffer, NUM_DIGITS-wide
// window, debounced step switch and auto-scroll timer, active-low 7-seg decode.
// Optional build macro REVERSE_STEP_EN adds a debounced backward step switch.
module scrolling_char_display #(
    parameter int NUM_DIGITS    = 2,
    parameter int DEPTH         = 16,
    parameter int DEBOUNCE_CLKS = 250000,
    parameter int STEP_CLKS     = 12500000
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    scrolling_char_display_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CLKS + 1);
    localparam int TM_W  = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
`ifdef REVERSE_STEP_EN
    localparam int unsigned NUM_SW = 2;
`else
    localparam int unsigned NUM_SW = 1;
`endif

    typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_SCROLL} state_t;

    state_t                  state, state_nx;
    logic [7:0]              msg_mem [DEPTH];
    logic [CNT_W-1:0]        count;
    logic [IDX_W-1:0]        s_idx, s_nx;
    logic [TM_W-1:0]         timer;
    logic [NUM_SW-1:0]       sw_raw, db_level, press;
    logic [DB_W-1:0]         db_cnt [NUM_SW];
    logic [NUM_DIGITS*8-1:0] char_r, char_nx;
    logic [NUM_DIGITS*7-1:0] seg_r;
    logic                    ovf_r, step_r;
    logic                    full, wr_ok, tick, fwd, back, advance, retreat;

`ifdef REVERSE_STEP_EN
    assign sw_raw = {bus.i_Switch_Back, bus.i_Switch};
`else
    assign sw_raw = bus.i_Switch;
`endif

    assign full  = (count == CNT_W'(DEPTH));
    assign wr_ok = bus.i_Wr_En & ~bus.i_Clear & ~full;
    assign tick  = (state == S_SCROLL) && (timer == TM_W'(STEP_CLKS - 1));

    function automatic logic [6:0] seg_decode(input logic [7:0] c);
        case (c)
            8'h30:        return 7'h40;
            8'h31:        return 7'h79;
            8'h32:        return 7'h24;
            8'h33:        return 7'h30;
            8'h34:        return 7'h19;
            8'h35:        return 7'h12;
            8'h36:        return 7'h02;
            8'h37:        return 7'h78;
            8'h38:        return 7'h00;
            8'h39:        return 7'h10;
            8'h41, 8'h61: return 7'h08;
            8'h42, 8'h62: return 7'h03;
            8'h43, 8'h63: return 7'h46;
            8'h44, 8'h64: return 7'h21;
            8'h45, 8'h65: return 7'h06;
            8'h46, 8'h66: return 7'h0E;
            8'h2D:        return 7'h3F;
            default:      return 7'h7F;
        endcase
    endfunction

    // Debounce: level flips after DEBOUNCE_CLKS consecutive differing samples
    always_ff @(posedge i_Clk) begin
        for (int unsigned i = 0; i < NUM_SW; i++) begin
            if (!i_Rst_L) begin
                db_cnt[i]   <= '0;
                db_level[i] <= 1'b0;
            end else if (sw_raw[i] != db_level[i]) begin
                if (db_cnt[i] == DB_W'(DEBOUNCE_CLKS - 1)) begin
                    db_cnt[i]   <= '0;
                    db_level[i] <= sw_raw[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end else begin
                db_cnt[i] <= '0;
            end
        end
    end

    // Press strobe: asserted on the cycle whose edge flips a debounced level 0->1
    always_comb begin
        press = '0;
        for (int unsigned i = 0; i < NUM_SW; i++)
            press[i] = sw_raw[i] & ~db_level[i] & (db_cnt[i] == DB_W'(DEBOUNCE_CLKS - 1));
    end

    // FSM state register
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) state <= S_EMPTY;
        else          state <= state_nx;
    end

    // FSM next state: clear dominates, otherwise mode follows i_Auto once non-empty
    always_comb begin
        state_nx = state;
        if (bus.i_Clear) begin
            state_nx = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY:  if (bus.i_Wr_En) state_nx = bus.i_Auto ? S_SCROLL : S_HOLD;
                S_HOLD:   if (bus.i_Auto)  state_nx = S_SCROLL;
                S_SCROLL: if (!bus.i_Auto) state_nx = S_HOLD;
                default:  state_nx = S_EMPTY;
            endcase
        end
    end

    // FSM outputs: window move requests and the next window start
    always_comb begin
        fwd  = 1'b0;
        back = 1'b0;
        if (!bus.i_Clear) begin
            case (state)
                S_HOLD:   fwd = press[0];
                S_SCROLL: fwd = press[0] | tick;
                default:  fwd = 1'b0;
            endcase
`ifdef REVERSE_STEP_EN
            if (state != S_EMPTY) back = press[1];
`endif
        end
        advance = fwd & ~back;
        retreat = back & ~fwd;
        s_nx    = s_idx;
        if (advance)
            s_nx = (CNT_W'(s_idx) + 1'b1 == count) ? '0 : s_idx + 1'b1;
        else if (retreat)
            s_nx = (s_idx == '0) ? IDX_W'(count - 1'b1) : s_idx - 1'b1;
    end

    // Count, window start, scroll timer and status pulses
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            count  <= '0;
            s_idx  <= '0;
            timer  <= '0;
            ovf_r  <= 1'b0;
            step_r <= 1'b0;
        end else begin
            ovf_r  <= bus.i_Wr_En & ~bus.i_Clear & full;
            step_r <= advance | retreat;
            timer  <= (state == S_SCROLL && !tick) ? timer + 1'b1 : '0;
            if (bus.i_Clear) begin
                count <= '0;
                s_idx <= '0;
            end else begin
                if (wr_ok) count <= count + 1'b1;
                s_idx <= s_nx;
            end
        end
    end

    // Message storage, appended at the current count
    always_ff @(posedge i_Clk) begin
        if (i_Rst_L && wr_ok) msg_mem[count[IDX_W-1:0]] <= bus.i_Wr_Char;
    end

    // Window select: walk from s with wrap at count so short messages repeat
    always_comb begin
        logic [IDX_W-1:0] idx;
        char_nx = {NUM_DIGITS{8'h20}};
        idx     = s_idx;
        if (count != '0) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                char_nx[8*k +: 8] = msg_mem[idx];
                idx = (CNT_W'(idx) + 1'b1 == count) ? '0 : idx + 1'b1;
            end
        end
    end

    // Registered character window, then registered segment decode of it
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            char_r <= {NUM_DIGITS{8'h20}};
            seg_r  <= '1;
        end else begin
            char_r <= char_nx;
            for (int unsigned k = 0; k < NUM_DIGITS; k++)
                seg_r[7*k +: 7] <= seg_decode(char_r[8*k +: 8]);
        end
    end

    assign bus.o_Char     = char_r;
    assign bus.o_Segments = seg_r;
    assign bus.o_Count    = count;
    assign bus.o_Full     = full;
    assign bus.o_Overflow = ovf_r;
    assign bus.o_Step     = step_r;
endmodule
